// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32 x 32-bit general-purpose register file.
// Two combinational read ports and one synchronous write port.
// Register 0 always reads as zero and has no storage behind it.

module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] Adr1,
  input  logic [ADDR_W-1:0] Adr2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2
);

  localparam int NREG = 2 ** ADDR_W;

  // R0 is not stored; the array starts at index 1 so no flops exist for it.
  logic [DATA_W-1:0] regs [1:NREG-1];

  // One-hot write select; address 0 never produces a select, so writes to R0 vanish.
  logic [NREG-1:1] wr_sel;

  // Decode the write address into a per-register enable.
  always_comb begin
    wr_sel = '0;
    for (int k = 1; k < NREG; k++) begin
      if (WrEn && (Awr == ADDR_W'(k))) begin
        wr_sel[k] = 1'b1;
      end
    end
  end

  // Register storage: reset clears everything and wins over a same-cycle write.
  always_ff @(posedge Clk) begin
    for (int k = 1; k < NREG; k++) begin
      if (Rst) begin
        regs[k] <= '0;
      end else if (wr_sel[k]) begin
        regs[k] <= Din;
      end
    end
  end

  // Read port 1: asynchronous mux, zero when addressing R0 (no Din bypass).
  always_comb begin
    Dout1 = '0;
    for (int k = 1; k < NREG; k++) begin
      if (Adr1 == ADDR_W'(k)) begin
        Dout1 = regs[k];
      end
    end
  end

  // Read port 2: identical mux on the second address.
  always_comb begin
    Dout2 = '0;
    for (int k = 1; k < NREG; k++) begin
      if (Adr2 == ADDR_W'(k)) begin
        Dout2 = regs[k];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed self-checking bench for reg_file_32x32.

module tb_reg_file_32x32;

  logic        Clk;
  logic        Rst;
  logic [4:0]  Adr1;
  logic [4:0]  Adr2;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [31:0] Dout1;
  logic [31:0] Dout2;

  int errors = 0;
  int checks = 0;

  reg_file_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Adr1  (Adr1),
    .Adr2  (Adr2),
    .Awr   (Awr),
    .Din   (Din),
    .WrEn  (WrEn),
    .Dout1 (Dout1),
    .Dout2 (Dout2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic edge1();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WrEn = 1'b1;
    Awr  = a;
    Din  = d;
    edge1();
    WrEn = 1'b0;
  endtask

  initial begin
    logic [31:0] pat;

    Rst = 1'b1; WrEn = 1'b0; Adr1 = '0; Adr2 = '0; Awr = '0; Din = '0;

    // 1. reset for one edge, then every address on both ports reads 0
    edge1();
    Rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      Adr1 = 5'(a);
      Adr2 = 5'(31 - a);
      #1;
      check($sformatf("reset_d1[%0d]", a), Dout1, 32'h0000_0000);
      check($sformatf("reset_d2[%0d]", 31 - a), Dout2, 32'h0000_0000);
    end

    // 2. R0 protection
    wr(5'd0, 32'hF0F0_F0F0);
    Adr1 = 5'd0; Adr2 = 5'd0;
    #1;
    check("r0_d1", Dout1, 32'h0000_0000);
    check("r0_d2", Dout2, 32'h0000_0000);

    // 3. basic write / read
    wr(5'd1, 32'h0F0F_0F0F);
    wr(5'd2, 32'hFFFF_FFFF);
    Adr1 = 5'd1; Adr2 = 5'd2;
    #1;
    check("basic_r1", Dout1, 32'h0F0F_0F0F);
    check("basic_r2", Dout2, 32'hFFFF_FFFF);
    Adr1 = 5'd0; Adr2 = 5'd3;
    #1;
    check("basic_r0", Dout1, 32'h0000_0000);
    check("basic_r3", Dout2, 32'h0000_0000);

    // 4. WrEn gating
    WrEn = 1'b0; Awr = 5'd1; Din = 32'h1234_5678;
    edge1(); edge1(); edge1();
    Adr1 = 5'd1;
    #1;
    check("gate_r1", Dout1, 32'h0F0F_0F0F);

    // 5. write timing: old value before the edge, new value right after
    Adr1 = 5'd5; Adr2 = 5'd5;
    WrEn = 1'b1; Awr = 5'd5; Din = 32'hAAAA_5555;
    #1;
    check("pre_edge_d1", Dout1, 32'h0000_0000);
    check("pre_edge_d2", Dout2, 32'h0000_0000);
    edge1();
    check("post_edge_d1", Dout1, 32'hAAAA_5555);
    check("post_edge_d2", Dout2, 32'hAAAA_5555);

    // 5b. reset beats a same-cycle write
    Rst = 1'b1; WrEn = 1'b1; Awr = 5'd5; Din = 32'h1111_1111;
    edge1();
    Rst = 1'b0; WrEn = 1'b0;
    #1;
    check("rst_prio_r5", Dout1, 32'h0000_0000);
    Adr2 = 5'd1;
    #1;
    check("rst_clr_r1", Dout2, 32'h0000_0000);

    // 6. full sweep
    for (int k = 1; k < 32; k++) begin
      pat = 32'(k) * 32'h0101_0101;
      wr(5'(k), pat);
    end
    for (int a = 0; a < 32; a++) begin
      pat = 32'(a) * 32'h0101_0101;
      Adr1 = 5'(a); Adr2 = 5'(a);
      #1;
      check($sformatf("sweep_same_d1[%0d]", a), Dout1, pat);
      check($sformatf("sweep_same_d2[%0d]", a), Dout2, pat);
      Adr2 = 5'(31 - a);
      #1;
      pat = 32'(31 - a) * 32'h0101_0101;
      check($sformatf("sweep_cross_d2[%0d]", 31 - a), Dout2, pat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
